// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared size encodings, FSM states and defaults for the MEM stage
package mips_mem_pkg;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    typedef enum logic {IDLE, RMW_WR} state_t;
endpackage

// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: EX/MEM inputs, data RAM port and MEM/WB outputs of the LSU
interface mem_stage_lsu_if import mips_mem_pkg::*; #(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_rd;
    logic                  mem_wr;
    logic [1:0]            size;
    logic                  sign_ext;
    logic [31:0]           alu_result;
    logic [DATA_WIDTH-1:0] store_data;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [4:0]            rd_dest;
    logic                  ram_we;
    logic                  ram_rd;
    logic [ADDR_WIDTH-1:0] address_mem;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  stall;
    logic                  wb_reg_write;
    logic [4:0]            wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  acc_err;

    modport slave (
        input  mem_rd, mem_wr, size, sign_ext, alu_result, store_data,
               reg_write, mem_to_reg, rd_dest, ram_rdata,
        output ram_we, ram_rd, address_mem, ram_wdata, stall,
               wb_reg_write, wb_rd, wb_data, acc_err
    );

    modport master (
        output mem_rd, mem_wr, size, sign_ext, alu_result, store_data,
               reg_write, mem_to_reg, rd_dest, ram_rdata,
        input  ram_we, ram_rd, address_mem, ram_wdata, stall,
               wb_reg_write, wb_rd, wb_data, acc_err
    );
endinterface

// File: rtl/mem_stage_lsu_lane_align.sv
// lane_align: big-endian lane extraction/extension for loads and payload merge for stores
module lane_align import mips_mem_pkg::*; (
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] payload,
    output logic [31:0] load_val,
    output logic [31:0] merged
);
    logic [4:0]  sh;
    logic [31:0] lane;
    logic [31:0] mask;

    // offset 0 is the most significant lane, so the shift is the distance to the LSB end
    always_comb begin
        sh       = size == SZ_BYTE ? {~offset, 3'b000} : size == SZ_HALF ? {~offset[1], 4'b0000} : 5'd0;
        lane     = word >> sh;
        mask     = size == SZ_BYTE ? 32'h0000_00FF << sh : size == SZ_HALF ? 32'h0000_FFFF << sh : '1;
        load_val = size == SZ_BYTE ? {{24{sign_ext & lane[7]}}, lane[7:0]} :
                   size == SZ_HALF ? {{16{sign_ext & lane[15]}}, lane[15:0]} : word;
        merged   = (word & ~mask) | ((payload << sh) & mask);
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit with sub-word read-modify-write and MEM/WB register
module mem_stage_lsu import mips_mem_pkg::*; #(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = 32
) (
    input logic           clk,
    input logic           rst,
    mem_stage_lsu_if.slave lsu
);
    state_t                state;
    state_t                state_n;
    logic [DATA_WIDTH-1:0] merge_q;
    logic [DATA_WIDTH-1:0] load_val;
    logic [DATA_WIDTH-1:0] merged;
    logic                  err;
    logic                  ld;
    logic                  st;
    logic                  sub_st;
    logic                  hold;

    lane_align u_lane (
        .word     (lsu.ram_rdata),
        .offset   (lsu.alu_result[1:0]),
        .size     (lsu.size),
        .sign_ext (lsu.sign_ext),
        .payload  (lsu.store_data),
        .load_val (load_val),
        .merged   (merged)
    );

    // access decode, next state and RAM strobes; strobes depend only on held inputs and state
    always_comb begin
        err  = (lsu.mem_rd | lsu.mem_wr) &
               (lsu.size == 2'b11 | (lsu.size == SZ_HALF & lsu.alu_result[0]) |
                (lsu.size == SZ_WORD & lsu.alu_result[1:0] != 2'b00) | (lsu.mem_rd & lsu.mem_wr));
        ld   = lsu.mem_rd & ~err;
        st   = lsu.mem_wr & ~err;
        sub_st = st & lsu.size != SZ_WORD;
        hold = state == IDLE & sub_st;
        state_n = hold ? RMW_WR : IDLE;
        lsu.ram_rd      = ~rst & state == IDLE & (ld | sub_st);
        lsu.ram_we      = ~rst & (state == RMW_WR | (state == IDLE & st & ~sub_st));
        lsu.ram_wdata   = state == RMW_WR ? merge_q : lsu.store_data;
        lsu.stall       = ~rst & hold;
        lsu.address_mem = lsu.alu_result[ADDR_WIDTH+1:2];
    end

    // state, merge buffer and MEM/WB register; MEM/WB holds during the RMW read cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            merge_q          <= '0;
            lsu.wb_reg_write <= 1'b0;
            lsu.wb_rd        <= '0;
            lsu.wb_data      <= '0;
            lsu.acc_err      <= 1'b0;
        end else begin
            state       <= state_n;
            lsu.acc_err <= err;
            if (hold) begin
                merge_q <= merged;
            end else begin
                lsu.wb_reg_write <= lsu.reg_write & ~err & ~lsu.mem_wr;
                lsu.wb_rd        <= lsu.rd_dest;
                lsu.wb_data      <= lsu.mem_to_reg ? load_val : lsu.alu_result;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed checks of loads, stores, RMW, access errors and reset
module tb_mem_stage_lsu;
    import mips_mem_pkg::*;

    logic        clk;
    logic        rst;
    logic        init;
    logic [31:0] mem [16];
    int          errs;
    int          checks;

    mem_stage_lsu_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

    mem_stage_lsu #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .lsu (bus)
    );

    assign bus.ram_rdata = mem[bus.address_mem];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'(i);
            mem[7]  <= 32'd33;
            mem[10] <= 32'd33;
        end else if (bus.ram_we) begin
            mem[bus.address_mem] <= bus.ram_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] sd, input logic rw,
                       input logic m2r, input logic [4:0] rdd);
        bus.mem_rd     = rd;
        bus.mem_wr     = wr;
        bus.size       = sz;
        bus.sign_ext   = sx;
        bus.alu_result = a;
        bus.store_data = sd;
        bus.reg_write  = rw;
        bus.mem_to_reg = m2r;
        bus.rd_dest    = rdd;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        errs = 0;
        checks = 0;
        rst = 1'b1;
        init = 1'b1;
        drv(1, 0, SZ_WORD, 0, 32'h1C, 0, 1, 1, 5);
        chk("rst_ram_rd", 32'(bus.ram_rd), 0);
        chk("rst_ram_we", 32'(bus.ram_we), 0);
        chk("rst_stall", 32'(bus.stall), 0);
        tick();
        tick();
        chk("rst_wb_reg_write", 32'(bus.wb_reg_write), 0);
        chk("rst_wb_rd", 32'(bus.wb_rd), 0);
        chk("rst_wb_data", bus.wb_data, 0);
        chk("rst_acc_err", 32'(bus.acc_err), 0);
        rst = 1'b0;
        init = 1'b0;
        #1;
        chk("lw_ram_rd", 32'(bus.ram_rd), 1);
        chk("lw_stall", 32'(bus.stall), 0);
        tick();
        chk("lw_wb_data", bus.wb_data, 32'h0000_0021);
        chk("lw_wb_rd", 32'(bus.wb_rd), 5);
        chk("lw_wb_reg_write", 32'(bus.wb_reg_write), 1);

        drv(0, 1, SZ_BYTE, 0, 32'h29, 32'hAB, 0, 0, 0);
        chk("sb_stall", 32'(bus.stall), 1);
        chk("sb_rd_ram_rd", 32'(bus.ram_rd), 1);
        chk("sb_rd_ram_we", 32'(bus.ram_we), 0);
        tick();
        chk("sb_wr_stall", 32'(bus.stall), 0);
        chk("sb_wr_ram_we", 32'(bus.ram_we), 1);
        chk("sb_wr_ram_rd", 32'(bus.ram_rd), 0);
        chk("sb_wr_wdata", bus.ram_wdata, 32'h00AB_0021);
        chk("sb_hold_wb_data", bus.wb_data, 32'h0000_0021);
        chk("sb_hold_wb_reg_write", 32'(bus.wb_reg_write), 1);
        tick();
        chk("sb_word10", mem[10], 32'h00AB_0021);
        chk("sb_wb_reg_write", 32'(bus.wb_reg_write), 0);
        drv(1, 0, SZ_BYTE, 1, 32'h29, 0, 1, 1, 6);
        tick();
        chk("lb_wb_data", bus.wb_data, 32'hFFFF_FFAB);
        chk("lb_wb_rd", 32'(bus.wb_rd), 6);
        drv(1, 0, SZ_BYTE, 0, 32'h29, 0, 1, 1, 6);
        tick();
        chk("lbu_wb_data", bus.wb_data, 32'h0000_00AB);

        drv(0, 1, SZ_HALF, 0, 32'h0E, 32'h1234, 0, 0, 0);
        chk("sh_stall", 32'(bus.stall), 1);
        tick();
        chk("sh_wdata", bus.ram_wdata, 32'h0000_1234);
        tick();
        chk("sh_word3", mem[3], 32'h0000_1234);
        drv(1, 0, SZ_HALF, 1, 32'h0C, 0, 1, 1, 7);
        tick();
        chk("lh_wb_data", bus.wb_data, 32'h0000_0000);
        chk("lh_wb_rd", 32'(bus.wb_rd), 7);

        drv(1, 0, SZ_WORD, 0, 32'h06, 0, 1, 1, 8);
        chk("mis_ram_rd", 32'(bus.ram_rd), 0);
        chk("mis_ram_we", 32'(bus.ram_we), 0);
        chk("mis_stall", 32'(bus.stall), 0);
        tick();
        chk("mis_acc_err", 32'(bus.acc_err), 1);
        chk("mis_wb_reg_write", 32'(bus.wb_reg_write), 0);
        drv(0, 0, SZ_WORD, 0, 32'h55, 0, 1, 0, 9);
        tick();
        chk("alu_acc_err", 32'(bus.acc_err), 0);
        chk("alu_wb_data", bus.wb_data, 32'h0000_0055);
        chk("alu_wb_reg_write", 32'(bus.wb_reg_write), 1);
        drv(1, 1, SZ_WORD, 0, 32'h1C, 0, 1, 1, 10);
        chk("rdwr_ram_rd", 32'(bus.ram_rd), 0);
        chk("rdwr_ram_we", 32'(bus.ram_we), 0);
        tick();
        chk("rdwr_acc_err", 32'(bus.acc_err), 1);
        chk("rdwr_wb_reg_write", 32'(bus.wb_reg_write), 0);

        drv(0, 1, SZ_BYTE, 0, 32'h30, 32'hFF, 0, 0, 0);
        chk("sbrst_stall", 32'(bus.stall), 1);
        tick();
        rst = 1'b1;
        #1;
        chk("sbrst_ram_we", 32'(bus.ram_we), 0);
        tick();
        rst = 1'b0;
        drv(0, 0, SZ_WORD, 0, 32'h0, 0, 0, 0, 0);
        chk("sbrst_idle_ram_we", 32'(bus.ram_we), 0);
        chk("sbrst_idle_stall", 32'(bus.stall), 0);
        chk("sbrst_wb_data", bus.wb_data, 0);
        chk("sbrst_wb_reg_write", 32'(bus.wb_reg_write), 0);
        chk("sbrst_acc_err", 32'(bus.acc_err), 0);
        chk("sbrst_word12", mem[12], 32'd12);
        tick();
        chk("sbrst_word12_later", mem[12], 32'd12);

        drv(0, 1, SZ_WORD, 0, 32'h3C, 32'hDEAD_BEEF, 0, 0, 0);
        chk("sw_ram_we", 32'(bus.ram_we), 1);
        chk("sw_stall", 32'(bus.stall), 0);
        chk("sw_wdata", bus.ram_wdata, 32'hDEAD_BEEF);
        tick();
        chk("sw_word15", mem[15], 32'hDEAD_BEEF);
        drv(1, 0, SZ_WORD, 0, 32'h3C, 0, 1, 1, 11);
        tick();
        chk("lw15_wb_data", bus.wb_data, 32'hDEAD_BEEF);
        chk("lw15_wb_rd", 32'(bus.wb_rd), 11);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
